// File: rtl/cnn_udiv_seq_11ns_7ns_if.sv
// Start/ready/done handshake and operand/result bus of the sequential unsigned divider.
// The dbz flag exists only when CNN_UDIV_DBZ_EN is defined.
interface cnn_udiv_seq_11ns_7ns_if #(
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 7
);
  logic                  start;
  logic                  ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  done;
  logic [din0_WIDTH-1:0] quotient;
  logic [din1_WIDTH-1:0] remainder;
`ifdef CNN_UDIV_DBZ_EN
  logic                  dbz;

  modport master (output start, din0, din1,
                  input  ready, done, quotient, remainder, dbz);
  modport slave  (input  start, din0, din1,
                  output ready, done, quotient, remainder, dbz);
`else
  modport master (output start, din0, din1,
                  input  ready, done, quotient, remainder);
  modport slave  (input  start, din0, din1,
                  output ready, done, quotient, remainder);
`endif
endinterface

// File: rtl/cnn_udiv_seq_11ns_7ns.sv
// Restoring shift-subtract unsigned divider, one quotient bit per cycle.
// Optional macro CNN_UDIV_DBZ_EN: early divide-by-zero completion and dbz flag.
module cnn_udiv_seq_11ns_7ns #(
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 7
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  cnn_udiv_seq_11ns_7ns_if.slave      bus
);
  localparam int CNT_W = $clog2(din0_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(din0_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                state_q,   state_d;
  logic [din0_WIDTH-1:0] dvd_q,     dvd_d;
  logic [din1_WIDTH-1:0] dvs_q,     dvs_d;
  logic [din1_WIDTH:0]   part_q,    part_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [din0_WIDTH-1:0] quo_q,     quo_d;
  logic [din1_WIDTH-1:0] rem_q,     rem_d;
`ifdef CNN_UDIV_DBZ_EN
  logic                  dbz_q,     dbz_d;
`endif

  logic [din1_WIDTH:0]   trial;
  logic [din1_WIDTH:0]   diff;
  logic                  qbit;
  logic [din1_WIDTH:0]   part_nxt;
  logic [din0_WIDTH-1:0] dvd_nxt;

  // Working dividend doubles as the quotient shift register: dividend MSBs
  // leave at the top while quotient bits enter at the bottom.
  always_comb begin
    trial    = {part_q[din1_WIDTH-1:0], dvd_q[din0_WIDTH-1]};
    diff     = trial - {1'b0, dvs_q};
    qbit     = (trial >= {1'b0, dvs_q});
    part_nxt = qbit ? diff : trial;
    dvd_nxt  = {dvd_q[din0_WIDTH-2:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef CNN_UDIV_DBZ_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      S_BUSY: begin
        part_d = part_nxt;
        dvd_d  = dvd_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_DONE;
          quo_d   = dvd_nxt;
          rem_d   = part_nxt[din1_WIDTH-1:0];
`ifdef CNN_UDIV_DBZ_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        if (bus.start) begin
          state_d = S_BUSY;
          dvd_d   = bus.din0;
          dvs_d   = bus.din1;
          part_d  = '0;
          cnt_d   = '0;
`ifdef CNN_UDIV_DBZ_EN
          if (bus.din1 == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef CNN_UDIV_DBZ_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef CNN_UDIV_DBZ_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign bus.ready     = (state_q != S_BUSY);
  assign bus.done      = (state_q == S_DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
`ifdef CNN_UDIV_DBZ_EN
  assign bus.dbz       = dbz_q;
`endif
endmodule

// File: tb/tb_cnn_udiv_seq_11ns_7ns.sv
// Directed-vector bench for the sequential 11/7-bit unsigned divider.
module tb_cnn_udiv_seq_11ns_7ns;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   n_vec  = 0;
  int   n_err  = 0;

  cnn_udiv_seq_11ns_7ns_if #(.din0_WIDTH(11), .din1_WIDTH(7)) bus ();

  cnn_udiv_seq_11ns_7ns #(.din0_WIDTH(11), .din1_WIDTH(7)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // elat counts clock edges from the accepting edge (inclusive) until done is seen.
  task automatic run_div(input string tag, input logic [10:0] a, input logic [6:0] b,
                         input int eq, input int er, input int elat, input bit poke);
    int lat;
    bit seen;
    @(negedge ap_clk);
    bus.start = 1'b1;
    bus.din0  = a;
    bus.din1  = b;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
      bus.start = poke && (lat >= 3) && (lat <= 5);
      if (poke && lat == 3) begin
        bus.din0 = 11'd5;
        bus.din1 = 7'd1;
        chk({tag, "_busy_ready"}, bus.ready, 0);
      end
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_lat"}, seen ? lat : 0, elat);
    chk({tag, "_quo"}, bus.quotient, eq);
    chk({tag, "_rem"}, bus.remainder, er);
`ifdef CNN_UDIV_DBZ_EN
    chk({tag, "_dbz"}, bus.dbz, (b == 7'd0) ? 1 : 0);
`endif
    @(negedge ap_clk);
    chk({tag, "_pulse"}, bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    bit  seen;
    bit  stable;
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;

    #12;
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_quo", bus.quotient, 0);
    chk("rst_rem", bus.remainder, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    run_div("d2047_127", 11'd2047, 7'd127, 16, 15, 12, 1'b0);
    run_div("d100_7",    11'd100,  7'd7,   14, 2,  12, 1'b0);
    run_div("d0_5",      11'd0,    7'd5,   0,  0,  12, 1'b0);
    run_div("d126_127",  11'd126,  7'd127, 0,  126, 12, 1'b0);
    run_div("d127_1",    11'd127,  7'd1,   127, 0, 12, 1'b0);
    run_div("ignore",    11'd2047, 7'd127, 16, 15, 12, 1'b1);

    // Back-to-back: second start held during the DONE cycle of the first.
    @(negedge ap_clk);
    bus.start = 1'b1;
    bus.din0  = 11'd100;
    bus.din1  = 7'd7;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    chk("b2b1_lat", seen ? lat : 0, 12);
    chk("b2b1_quo", bus.quotient, 14);
    chk("b2b1_rem", bus.remainder, 2);
    bus.start = 1'b1;
    bus.din0  = 11'd50;
    bus.din1  = 7'd3;
    lat = 0; seen = 1'b0; stable = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
      else if (bus.quotient != 11'd14 || bus.remainder != 7'd2) stable = 1'b0;
    end
    chk("b2b2_lat", seen ? lat : 0, 12);
    chk("b2b_hold", stable, 1);
    chk("b2b2_quo", bus.quotient, 16);
    chk("b2b2_rem", bus.remainder, 2);

    // Asynchronous reset at step 5 of 2047/127.
    @(negedge ap_clk);
    bus.start = 1'b1;
    bus.din0  = 11'd2047;
    bus.din1  = 7'd127;
    for (int i = 0; i < 6; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      bus.start = 1'b0;
    end
    #2 ap_rst = 1'b1;
    #1;
    chk("arst_quo", bus.quotient, 0);
    chk("arst_rem", bus.remainder, 0);
    chk("arst_ready", bus.ready, 1);
    chk("arst_done", bus.done, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (bus.done) seen = 1'b1;
    end
    chk("arst_nodone", seen, 0);
    run_div("post_rst", 11'd100, 7'd7, 14, 2, 12, 1'b0);

`ifdef CNN_UDIV_DBZ_EN
    run_div("d1234_0", 11'd1234, 7'd0, 2047, 0, 1, 1'b0);
`else
    run_div("d1234_0", 11'd1234, 7'd0, 2047, 82, 12, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
